cpu_dispatch_n: RTL and testbench
=================================

CPU_DISPATCH_N -- requirements
Module: cpu_dispatch_n

Interface
REQ-001 Parameter: N, 4, data/register width; SHALL match the n of the processor it feeds.
REQ-002 Parameter: DEPTH, 4, instruction queue entries (power of two, >= 2).
REQ-003 Parameter: TMO, 7, max cycles in WAIT without done before timeout.
REQ-004 clock  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  host offers an instruction.
REQ-007 in_ready  output  1  queue can accept; equals !full.
REQ-008 in_f, in_rx, in_ry  input  2 each  opcode, operand1 select, operand2 select.
REQ-009 in_data  input  N  external load value paired with the instruction.
REQ-010 done  input  1  processor completion strobe.
REQ-011 w  output  1  one-cycle instruction-start strobe to processor.
REQ-012 F, Rx, Ry  output  2 each  instruction fields to processor.
REQ-013 data  output  N  external data to processor bus driver.
REQ-014 busy  output  1  high when state != IDLE or queue non-empty.
REQ-015 retired  output  8  completed-instruction count.
REQ-016 timeout_err  output  1  sticky timeout flag.

Function
REQ-017 Push SHALL occur when in_valid & in_ready at a rising edge; in_ready SHALL depend only on full (no same-cycle pop credit).
REQ-018 Queue SHALL be FIFO-ordered, storing {in_f,in_rx,in_ry,in_data} per entry; pointers wrap modulo DEPTH.
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, HALT.
REQ-020 IDLE: if queue non-empty, pop head into hold register and go to ISSUE; else remain.
REQ-021 ISSUE: w=1 for exactly one cycle, F/Rx/Ry/data from hold register; next state WAIT.
REQ-022 WAIT: w=0, F/Rx/Ry/data held stable; on done=1 go to IDLE and increment retired.
REQ-023 Outputs w, F, Rx, Ry, data SHALL be registered; the hold register is not modified outside IDLE pop.
REQ-024 Latency: instruction accepted at end of cycle c into empty idle block pops in c+1 and drives w=1 in c+2.
REQ-025 Back-to-back: done in cycle d gives IDLE in d+1 and next w=1 in d+2, so w falls when processor counter is at T0.
REQ-026 done outside WAIT (including the ISSUE cycle) SHALL be ignored.
REQ-027 WAIT counter SHALL start at 0 on WAIT entry; if it reaches TMO without done, set timeout_err and go to HALT.
REQ-028 HALT: no further issue, w=0; queue SHALL continue accepting until full; exit only by reset.
REQ-029 retired SHALL wrap 255 -> 0.
REQ-030 Full queue: in_ready=0, in_valid ignored; empty queue: IDLE holds, no pop.

Reset
REQ-031 Reset SHALL empty the queue, force IDLE, clear hold register, w=0, F=Rx=Ry=0, data=0, retired=0, timeout_err=0, WAIT counter=0.
REQ-032 Reset SHALL take priority over push, pop and done in the same cycle, including mid-WAIT.
REQ-033 After reset, in_ready=1 and busy=0 in the first cycle.

Structure
REQ-034 Shared package cpu_pkg SHALL hold opcode enum (LOAD=00, MOVE=01, ADD=10, SUB=11), the dispatch state enum, and the instruction-entry struct type.
REQ-035 Queue SHALL be a separate sub-module fifo_n (parameterised width, depth; push/pop/full/empty); FSM, hold register and counters live in cpu_dispatch_n.

Verification
REQ-036 Single LOAD R2 data=9, done pulsed in the cycle after w -> w=1 two cycles after accept, F=00 Rx=10 data=9 stable until done, retired=1.
REQ-037 Four instructions pushed back-to-back (ADD, SUB, MOVE, LOAD) -> in_ready low after 4th, issue order preserved, w spacing = done cycle + 2.
REQ-038 Fifth push while full -> in_ready=0, entry dropped, queue contents unchanged.
REQ-039 Never assert done after issue -> timeout_err=1 after TMO=7 WAIT cycles, state HALT, no further w even with queue non-empty.
REQ-040 Reset asserted mid-WAIT with 3 queued -> next cycle w=0, queue empty, retired=0, timeout_err=0; stray done ignored.
REQ-041 256 completed instructions -> retired wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, dispatch-state and instruction-entry types
package cpu_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_MOVE = 2'b01,
      OP_ADD  = 2'b10,
      OP_SUB  = 2'b11
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HALT  = 2'd3
   } disp_state_e;

   // Instruction fields of a queue entry; the N-bit load value is appended by the user.
   typedef struct packed {
      opcode_e    f;
      logic [1:0] rx;
      logic [1:0] ry;
   } instr_hdr_t;

   localparam int HDR_W = $bits(instr_hdr_t);

endpackage

// File: rtl/fifo_n.sv
// rtl/fifo_n.sv - synchronous FIFO with wrap-bit pointers and show-ahead read
module fifo_n #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage carries no reset; an emptied queue never exposes stale entries.
   always_ff @(posedge clock) begin
      if (!reset && do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/cpu_dispatch_n.sv
// rtl/cpu_dispatch_n.sv - queued instruction dispatcher with issue strobe and timeout
module cpu_dispatch_n
   import cpu_pkg::*;
#(
   parameter int N     = 4,
   parameter int DEPTH = 4,
   parameter int TMO   = 7
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_f,
   input  logic [1:0]   in_rx,
   input  logic [1:0]   in_ry,
   input  logic [N-1:0] in_data,
   input  logic         done,
   output logic         w,
   output logic [1:0]   F,
   output logic [1:0]   Rx,
   output logic [1:0]   Ry,
   output logic [N-1:0] data,
   output logic         busy,
   output logic [7:0]   retired,
   output logic         timeout_err
);

   localparam int EW = HDR_W + N;
   localparam int CW = $clog2(TMO + 1);

   disp_state_e    state_q, state_d;
   instr_hdr_t     hold_hdr_q, hold_hdr_d;
   logic [N-1:0]   hold_data_q, hold_data_d;
   logic           w_q, w_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [7:0]     retired_q, retired_d;
   logic           tmo_q, tmo_d;

   logic           q_full;
   logic           q_empty;
   logic           q_pop;
   logic [EW-1:0]  q_wdata;
   logic [EW-1:0]  q_rdata;
   instr_hdr_t     head_hdr;
   logic [N-1:0]   head_data;
   logic [CW-1:0]  cnt_inc;

   assign q_wdata   = {in_f, in_rx, in_ry, in_data};
   assign head_hdr  = instr_hdr_t'(q_rdata[EW-1:N]);
   assign head_data = q_rdata[N-1:0];
   assign cnt_inc   = cnt_q + 1'b1;

   fifo_n #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clock   (clock),
      .reset   (reset),
      .push_i  (in_valid),
      .pop_i   (q_pop),
      .wdata_i (q_wdata),
      .rdata_o (q_rdata),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   always_comb begin
      state_d     = state_q;
      hold_hdr_d  = hold_hdr_q;
      hold_data_d = hold_data_q;
      w_d         = 1'b0;
      cnt_d       = cnt_q;
      retired_d   = retired_q;
      tmo_d       = tmo_q;
      q_pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!q_empty) begin
               q_pop       = 1'b1;
               hold_hdr_d  = head_hdr;
               hold_data_d = head_data;
               w_d         = 1'b1;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // done wins over timeout on the last permitted WAIT cycle.
            if (done) begin
               retired_d = retired_q + 8'd1;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end else if (cnt_inc == CW'(TMO)) begin
               cnt_d   = cnt_inc;
               tmo_d   = 1'b1;
               state_d = ST_HALT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         hold_hdr_q  <= '0;
         hold_data_q <= '0;
         w_q         <= 1'b0;
         cnt_q       <= '0;
         retired_q   <= '0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_hdr_q  <= hold_hdr_d;
         hold_data_q <= hold_data_d;
         w_q         <= w_d;
         cnt_q       <= cnt_d;
         retired_q   <= retired_d;
         tmo_q       <= tmo_d;
      end
   end

   assign in_ready    = !q_full;
   assign w           = w_q;
   assign F           = hold_hdr_q.f;
   assign Rx          = hold_hdr_q.rx;
   assign Ry          = hold_hdr_q.ry;
   assign data        = hold_data_q;
   assign busy        = (state_q != ST_IDLE) || !q_empty;
   assign retired     = retired_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_cpu_dispatch_n.sv
// tb/tb_cpu_dispatch_n.sv - directed self-checking bench for cpu_dispatch_n
module tb_cpu_dispatch_n;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int TMO   = 7;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   in_f = '0;
   logic [1:0]   in_rx = '0;
   logic [1:0]   in_ry = '0;
   logic [N-1:0] in_data = '0;
   logic         done = 1'b0;
   logic         w;
   logic [1:0]   F;
   logic [1:0]   Rx;
   logic [1:0]   Ry;
   logic [N-1:0] data;
   logic         busy;
   logic [7:0]   retired;
   logic         timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   cpu_dispatch_n #(.N(N), .DEPTH(DEPTH), .TMO(TMO)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_f        (in_f),
      .in_rx       (in_rx),
      .in_ry       (in_ry),
      .in_data     (in_data),
      .done        (done),
      .w           (w),
      .F           (F),
      .Rx          (Rx),
      .Ry          (Ry),
      .data        (data),
      .busy        (busy),
      .retired     (retired),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] f, input logic [1:0] rx,
                        input logic [1:0] ry, input logic [N-1:0] d);
      in_valid = v;
      in_f     = f;
      in_rx    = rx;
      in_ry    = ry;
      in_data  = d;
   endtask

   task automatic run_one(input logic [N-1:0] d);
      drive(1'b1, 2'b10, 2'b01, 2'b10, d);
      tick;
      drive(1'b0, 2'b00, 2'b00, 2'b00, 4'h0);
      tick;
      tick;
      done = 1'b1;
      tick;
      done = 1'b0;
   endtask

   logic [1:0]   exp_f  [4];
   logic [1:0]   exp_rx [4];
   logic [1:0]   exp_ry [4];
   logic [N-1:0] exp_d  [4];

   initial begin
      exp_f[0] = 2'b10; exp_rx[0] = 2'd0; exp_ry[0] = 2'd1; exp_d[0] = 4'h3;
      exp_f[1] = 2'b11; exp_rx[1] = 2'd2; exp_ry[1] = 2'd3; exp_d[1] = 4'h6;
      exp_f[2] = 2'b01; exp_rx[2] = 2'd3; exp_ry[2] = 2'd0; exp_d[2] = 4'hA;
      exp_f[3] = 2'b00; exp_rx[3] = 2'd1; exp_ry[3] = 2'd2; exp_d[3] = 4'hC;

      // Reset state
      tick;
      tick;
      reset = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_w", 32'(w), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      check("rst_timeout", 32'(timeout_err), 32'd0);
      check("rst_fields", 32'({F, Rx, Ry, data}), 32'd0);

      // Single LOAD R2 <- 9
      drive(1'b1, 2'b00, 2'b10, 2'b00, 4'd9);
      tick;
      drive(1'b0, 2'b00, 2'b00, 2'b00, 4'h0);
      check("load_c1_w", 32'(w), 32'd0);
      check("load_c1_busy", 32'(busy), 32'd1);
      tick;
      check("load_w", 32'(w), 32'd1);
      check("load_F", 32'(F), 32'd0);
      check("load_Rx", 32'(Rx), 32'd2);
      check("load_data", 32'(data), 32'd9);
      tick;
      check("load_w_fall", 32'(w), 32'd0);
      check("load_hold", 32'({F, Rx, data}), 32'({2'b00, 2'b10, 4'd9}));
      done = 1'b1;
      tick;
      done = 1'b0;
      check("load_retired", 32'(retired), 32'd1);
      check("load_idle_busy", 32'(busy), 32'd0);

      // Four pushes while a MOVE waits, then a fifth into the full queue
      drive(1'b1, 2'b01, 2'b01, 2'b11, 4'h5);
      tick;
      drive(1'b0, 2'b00, 2'b00, 2'b00, 4'h0);
      tick;
      check("mv_w", 32'(w), 32'd1);
      check("mv_F", 32'(F), 32'd1);
      tick;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, exp_f[k], exp_rx[k], exp_ry[k], exp_d[k]);
         check("fill_in_ready", 32'(in_ready), 32'd1);
         tick;
      end
      check("full_in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 2'b00, 2'b11, 2'b11, 4'hF);
      tick;
      check("full_drop_in_ready", 32'(in_ready), 32'd0);
      drive(1'b0, 2'b00, 2'b00, 2'b00, 4'h0);
      done = 1'b1;
      tick;
      done = 1'b0;
      check("mv_retired", 32'(retired), 32'd2);
      check("mv_idle_w", 32'(w), 32'd0);
      tick;
      for (int k = 0; k < 4; k++) begin
         check("b2b_w", 32'(w), 32'd1);
         check("b2b_fields", 32'({F, Rx, Ry, data}),
               32'({exp_f[k], exp_rx[k], exp_ry[k], exp_d[k]}));
         tick;
         done = 1'b1;
         tick;
         done = 1'b0;
         check("b2b_idle_w", 32'(w), 32'd0);
         if (k == 3) check("b2b_drained_busy", 32'(busy), 32'd0);
         tick;
      end
      check("drop_no_issue_w", 32'(w), 32'd0);
      check("b2b_retired", 32'(retired), 32'd6);

      // Timeout: done during ISSUE is ignored, then no done at all
      drive(1'b1, 2'b10, 2'b01, 2'b10, 4'h7);
      tick;
      drive(1'b1, 2'b11, 2'b00, 2'b00, 4'h4);
      tick;
      drive(1'b0, 2'b00, 2'b00, 2'b00, 4'h0);
      check("to_issue_w", 32'(w), 32'd1);
      done = 1'b1;
      tick;
      done = 1'b0;
      check("issue_done_ignored", 32'(retired), 32'd6);
      for (int i = 0; i < TMO - 1; i++) tick;
      check("to_not_yet", 32'(timeout_err), 32'd0);
      tick;
      check("to_flag", 32'(timeout_err), 32'd1);
      check("to_busy", 32'(busy), 32'd1);
      done = 1'b1;
      tick;
      done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("halt_no_w", 32'(w), 32'd0);
         tick;
      end
      check("halt_retired", 32'(retired), 32'd6);
      check("halt_hold", 32'({F, data}), 32'({2'b10, 4'h7}));
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'b01, 2'b10, 2'b01, 4'h1);
         tick;
      end
      drive(1'b0, 2'b00, 2'b00, 2'b00, 4'h0);
      check("halt_full", 32'(in_ready), 32'd0);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("halt_rst_timeout", 32'(timeout_err), 32'd0);
      check("halt_rst_busy", 32'(busy), 32'd0);
      check("halt_rst_in_ready", 32'(in_ready), 32'd1);

      // Reset mid-WAIT with three queued, plus a same-cycle push and done
      drive(1'b1, 2'b00, 2'b00, 2'b01, 4'h1);
      tick;
      drive(1'b1, 2'b01, 2'b01, 2'b01, 4'h2);
      tick;
      drive(1'b1, 2'b10, 2'b10, 2'b10, 4'h3);
      tick;
      drive(1'b1, 2'b11, 2'b11, 2'b11, 4'h4);
      tick;
      check("mw_w", 32'(w), 32'd0);
      check("mw_data", 32'(data), 32'd1);
      reset = 1'b1;
      done  = 1'b1;
      drive(1'b1, 2'b11, 2'b11, 2'b11, 4'h5);
      tick;
      reset = 1'b0;
      drive(1'b0, 2'b00, 2'b00, 2'b00, 4'h0);
      check("mw_rst_w", 32'(w), 32'd0);
      check("mw_rst_busy", 32'(busy), 32'd0);
      check("mw_rst_retired", 32'(retired), 32'd0);
      check("mw_rst_timeout", 32'(timeout_err), 32'd0);
      check("mw_rst_data", 32'(data), 32'd0);
      tick;
      done = 1'b0;
      check("stray_done_retired", 32'(retired), 32'd0);
      tick;
      check("mw_empty_no_w", 32'(w), 32'd0);

      // retired wraps after 256 completions
      for (int i = 0; i < 255; i++) run_one(4'(i));
      check("ret_255", 32'(retired), 32'd255);
      run_one(4'hE);
      check("ret_wrap", 32'(retired), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
